// File: rtl/soma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soma_pkg
// Description : Shared types and helpers for the soma_pipe adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package soma_pkg;

    // Operation encoding: bit 0 selects subtract, bit 1 selects saturation.
    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ADD_SAT = 2'b10,
        OP_SUB_SAT = 2'b11
    } op_t;

    // Widest operand the saturation helpers can describe.
    localparam int unsigned c_MAX_WIDTH = 256;

    // Most negative value of a width-bit two's-complement number.
    function automatic logic [c_MAX_WIDTH-1:0] sat_min(input int unsigned width);
        logic [c_MAX_WIDTH-1:0] v_one;
        v_one = {{(c_MAX_WIDTH-1){1'b0}}, 1'b1};
        return v_one << (width - 1);
    endfunction

    // Most positive value of a width-bit two's-complement number.
    function automatic logic [c_MAX_WIDTH-1:0] sat_max(input int unsigned width);
        return sat_min(width) - {{(c_MAX_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/soma_seg.sv
`default_nettype none
// ============================================================================
// Module      : soma_seg
// Description : Combinational SEG-bit ripple segment built from full_adder
//               cells; exposes the carry into its top bit for overflow use.
// Revision    : 1.0 - initial release
// ============================================================================
module soma_seg
    import soma_pkg::*;
#(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_cmsb
);

    // w_carry[i] is the carry into bit i of the segment.
    logic [SEG:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (w_carry[i]),
            .o_sum  (o_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    assign o_cout = w_carry[SEG];
    assign o_cmsb = w_carry[SEG-1];

endmodule
`default_nettype wire

// File: rtl/soma_pipe.sv
`default_nettype none
// ============================================================================
// Module      : soma_pipe
// Description : Pipelined two's-complement add/sub with optional saturation.
//               The carry chain is cut into STAGES segments; each rank holds
//               finished low result bits, untouched high A bits, the still
//               unconsumed high B' bits and the segment carry.
// Revision    : 1.0 - initial release
// ============================================================================
module soma_pipe
    import soma_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic             out_carry
);

    localparam int unsigned c_SEG = WIDTH / STAGES;

    localparam logic [c_MAX_WIDTH-1:0] c_SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [c_MAX_WIDTH-1:0] c_SAT_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0]       c_SAT_MAX      = c_SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]       c_SAT_MIN      = c_SAT_MIN_FULL[WIDTH-1:0];

    op_t  w_op;
    logic w_is_sub;
    logic w_is_sat;
    logic w_advance;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_overflow;
    logic             r_out_carry;

    assign w_op     = op_t'(in_op);
    assign w_is_sub = (w_op == OP_SUB) || (w_op == OP_SUB_SAT);
    assign w_is_sat = (w_op == OP_ADD_SAT) || (w_op == OP_SUB_SAT);

    // The whole pipe moves as one: it only freezes when a result is waiting.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_overflow;
    assign out_carry    = r_out_carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned c_LO = k * c_SEG;
        // B' bits from segment k upward that this stage still has to see.
        localparam int unsigned c_BW = WIDTH - c_LO;

        logic             w_valid;
        logic             w_cin;
        logic             w_sat;
        logic [WIDTH-1:0] w_mix;
        logic [c_BW-1:0]  w_bh;
        logic [c_SEG-1:0] w_seg_sum;
        logic             w_cout;
        logic             w_cmsb;
        logic [WIDTH-1:0] w_next_mix;

        if (k == 0) begin : g_head
            assign w_valid = in_valid;
            assign w_mix   = in_a;
            assign w_bh    = in_b ^ {WIDTH{w_is_sub}};
            assign w_cin   = w_is_sub;
            assign w_sat   = w_is_sat;
        end else begin : g_link
            assign w_valid = g_stage[k-1].g_mid.r_valid;
            assign w_mix   = g_stage[k-1].g_mid.r_mix;
            assign w_bh    = g_stage[k-1].g_mid.r_bh;
            assign w_cin   = g_stage[k-1].g_mid.r_carry;
            assign w_sat   = g_stage[k-1].g_mid.r_sat;
        end

        soma_seg #(
            .SEG (c_SEG)
        ) u_seg (
            .i_a    (w_mix[c_LO +: c_SEG]),
            .i_b    (w_bh[c_SEG-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_seg_sum),
            .o_cout (w_cout),
            .o_cmsb (w_cmsb)
        );

        // Replace this segment's A bits with its freshly computed result bits.
        always_comb begin
            w_next_mix                  = w_mix;
            w_next_mix[c_LO +: c_SEG]   = w_seg_sum;
        end

        if (k < STAGES - 1) begin : g_mid
            logic                   r_valid;
            logic                   r_carry;
            logic                   r_sat;
            logic [WIDTH-1:0]       r_mix;
            logic [c_BW-c_SEG-1:0]  r_bh;
            logic                   w_unused_cmsb;

            // Only the top segment's carry-into-MSB feeds overflow.
            assign w_unused_cmsb = w_cmsb;

            // Intermediate rank: carry the partial beat to the next segment.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_sat   <= 1'b0;
                    r_mix   <= '0;
                    r_bh    <= '0;
                end else if (w_advance) begin
                    r_valid <= w_valid;
                    r_carry <= w_cout;
                    r_sat   <= w_sat;
                    r_mix   <= w_next_mix;
                    r_bh    <= w_bh[c_BW-1:c_SEG];
                end
            end
        end else begin : g_tail
            logic             w_ovf;
            logic [WIDTH-1:0] w_final;

            // Overflow always reflects the raw sum, saturated or not.
            assign w_ovf   = w_cmsb ^ w_cout;
            // Clamp toward the sign of A, which is the overflow direction.
            assign w_final = (w_sat && w_ovf)
                           ? (w_mix[WIDTH-1] ? c_SAT_MIN : c_SAT_MAX)
                           : w_next_mix;

            // Output rank: registered result and flags.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid    <= 1'b0;
                    r_out_sum      <= '0;
                    r_out_overflow <= 1'b0;
                    r_out_carry    <= 1'b0;
                end else if (w_advance) begin
                    r_out_valid    <= w_valid;
                    r_out_sum      <= w_final;
                    r_out_overflow <= w_ovf;
                    r_out_carry    <= w_cout;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soma_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_soma_pipe
// Description : Scoreboard bench for soma_pipe over several WIDTH/STAGES
//               configurations with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soma_pipe;

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
        logic        carry;
    } exp_t;

    logic clk;
    int   total      = 0;
    int   bad        = 0;
    int   done_count = 0;

    task automatic chk(input string name, input int inst, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cfg%0d: got %h want %h", name, inst, got, want);
        end
    endtask

    task automatic bound_fail(input string name, input int inst);
        total++;
        bad++;
        $display("FAIL %s cfg%0d: wait bound expired", name, inst);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W = (g == 2) ? 8 : (g == 3) ? 32 : 16;
        localparam int S = (g == 1) ? 1 : (g == 2) ? 8 : 4;

        logic         rst;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] in_a;
        logic [W-1:0] in_b;
        logic [1:0]   in_op;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] out_sum;
        logic         out_overflow;
        logic         out_carry;

        exp_t q[$];
        int   mode;

        soma_pipe #(
            .WIDTH  (W),
            .STAGES (S)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid),
            .in_ready     (in_ready),
            .in_a         (in_a),
            .in_b         (in_b),
            .in_op        (in_op),
            .out_valid    (out_valid),
            .out_ready    (out_ready),
            .out_sum      (out_sum),
            .out_overflow (out_overflow),
            .out_carry    (out_carry)
        );

        // Exact integer arithmetic on the signed/unsigned operand values.
        function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] op);
            exp_t        e;
            longint      ua, ub, sa, sb, lim, mx, mn, ex, res;
            logic [63:0] r;
            lim = longint'(1) << W;
            mx  = (lim >> 1) - 1;
            mn  = -(lim >> 1);
            ua  = longint'(a);
            ub  = longint'(b);
            sa  = a[W-1] ? ua - lim : ua;
            sb  = b[W-1] ? ub - lim : ub;
            ex  = op[0] ? sa - sb : sa + sb;
            e.ovf   = (ex > mx) || (ex < mn);
            e.carry = op[0] ? (ua >= ub) : ((ua + ub) >= lim);
            res = ex;
            if (op[1] && e.ovf) res = (ex > mx) ? mx : mn;
            r = res;
            e.sum = 32'(r[W-1:0]);
            return e;
        endfunction

        task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op);
            bit acc;
            int guard;
            acc      = 1'b0;
            guard    = 0;
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            in_op    = op;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) bound_fail("send", g);
        endtask

        task automatic drain();
            int guard;
            guard     = 0;
            in_valid  = 1'b0;
            mode      = 1;
            out_ready = 1'b1;
            while ((q.size() != 0 || out_valid) && guard < 300) begin
                @(posedge clk);
                #1;
                guard++;
            end
            chk("drain_left", g, 64'(q.size()), 64'd0);
        endtask

        task automatic latency();
            int cnt;
            cnt = 0;
            send(W'($urandom), W'($urandom), 2'($urandom));
            in_valid = 1'b0;
            cnt = 1;
            while (!out_valid && cnt < 4 * S + 10) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            chk("latency", g, 64'(cnt), 64'(S));
        endtask

        // Downstream backpressure: fixed low, fixed high or random.
        initial begin
            mode      = 1;
            out_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                out_ready = (mode == 2) ? 1'($urandom) : (mode == 1);
            end
        end

        // Scoreboard push at each accepted beat.
        initial begin
            forever begin
                @(negedge clk);
                if (!rst && in_valid && in_ready)
                    q.push_back(model(in_a, in_b, in_op));
            end
        end

        // Output monitor: ordering, handshake relation and stall stability.
        initial begin
            exp_t         e;
            bit           hold;
            logic [W-1:0] h_sum;
            logic         h_ovf, h_carry;
            hold = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    hold = 1'b0;
                end else begin
                    chk("in_ready", g, 64'(in_ready), 64'(!(out_valid && !out_ready)));
                    if (hold) begin
                        chk("hold_sum", g, 64'(out_sum), 64'(h_sum));
                        chk("hold_flags", g, {62'd0, out_overflow, out_carry},
                            {62'd0, h_ovf, h_carry});
                    end
                    hold    = out_valid && !out_ready;
                    h_sum   = out_sum;
                    h_ovf   = out_overflow;
                    h_carry = out_carry;
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            bound_fail("unexpected_beat", g);
                        end else begin
                            e = q.pop_front();
                            chk("sum", g, 64'(out_sum), 64'(e.sum));
                            chk("overflow", g, 64'(out_overflow), 64'(e.ovf));
                            chk("carry", g, 64'(out_carry), 64'(e.carry));
                        end
                    end
                end
            end
        end

        // Stimulus sequence for this configuration.
        initial begin
            logic [W-1:0] cv[5];
            rst      = 1'b1;
            in_valid = 1'b0;
            in_a     = '0;
            in_b     = '0;
            in_op    = 2'b00;
            cv[0] = '0;
            cv[1] = W'(1);
            cv[2] = {1'b0, {(W-1){1'b1}}};
            cv[3] = {1'b1, {(W-1){1'b0}}};
            cv[4] = '1;

            repeat (2) @(posedge clk);
            #1;
            chk("rst_valid", g, 64'(out_valid), 64'd0);
            chk("rst_sum", g, 64'(out_sum), 64'd0);
            chk("rst_flags", g, {62'd0, out_overflow, out_carry}, 64'd0);
            rst = 1'b0;
            #1;
            chk("rst_in_ready", g, 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;

            if (W == 16) begin
                send(W'(16'h7FFF), W'(16'h0001), 2'b00);
                send(W'(16'h7FFF), W'(16'h0001), 2'b10);
                send(W'(16'h8000), W'(16'h0001), 2'b11);
                send(W'(16'h0000), W'(16'h0001), 2'b01);
                send(W'(16'hFFFF), W'(16'h0001), 2'b00);
                send(W'(16'h0FFF), W'(16'h0001), 2'b00);
                send(W'(16'h00FF), W'(16'h0F01), 2'b00);
            end

            for (int op = 0; op < 4; op++)
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        send(cv[i], cv[j], 2'(op));
            drain();

            latency();
            drain();

            mode = 2;
            for (int n = 0; n < 32; n++)
                send(W'($urandom), W'($urandom), 2'($urandom));
            drain();

            mode      = 0;
            out_ready = 1'b0;
            for (int n = 0; n < S; n++)
                send(W'($urandom) | W'(1), W'($urandom), 2'($urandom));
            in_valid = 1'b0;
            #2;
            chk("stall_full", g, 64'(out_valid), 64'd1);
            rst = 1'b1;
            #1;
            chk("arst_valid", g, 64'(out_valid), 64'd0);
            chk("arst_sum", g, 64'(out_sum), 64'd0);
            chk("arst_flags", g, {62'd0, out_overflow, out_carry}, 64'd0);
            q.delete();
            @(posedge clk);
            #1;
            mode      = 1;
            out_ready = 1'b1;
            rst       = 1'b0;
            #1;
            latency();
            drain();

            done_count++;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (done_count < 4 && cyc < 40000) begin
            @(posedge clk);
            cyc++;
        end
        if (done_count < 4) bound_fail("global_timeout", -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
